// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall vector width,
// stall masks and controller state codes.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  // Stall bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_LU   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_DISCARD = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
();

  logic               rdy_in;
  logic               stallreq_if_in;
  logic               stallreq_mem_in;
  logic               if_busy_in;
  logic               if_fetch_done_in;
  logic               ex_is_load_in;
  logic               ex_wr_in;
  logic [4:0]         ex_rsd_in;
  logic [4:0]         id_rs1_in;
  logic [4:0]         id_rs2_in;
  logic               id_rs1_rd_in;
  logic               id_rs2_rd_in;
  logic               br_taken_in;
  logic [31:0]        br_target_in;
  logic [STALL_W-1:0] stall_out;
  logic               flush_out;
  logic               redirect_valid_out;
  logic [31:0]        redirect_pc_out;
  logic               if_discard_out;
  logic               hang_out;

  modport master (
    output rdy_in, stallreq_if_in, stallreq_mem_in, if_busy_in, if_fetch_done_in,
           ex_is_load_in, ex_wr_in, ex_rsd_in, id_rs1_in, id_rs2_in,
           id_rs1_rd_in, id_rs2_rd_in, br_taken_in, br_target_in,
    input  stall_out, flush_out, redirect_valid_out, redirect_pc_out,
           if_discard_out, hang_out
  );

  modport slave (
    input  rdy_in, stallreq_if_in, stallreq_mem_in, if_busy_in, if_fetch_done_in,
           ex_is_load_in, ex_wr_in, ex_rsd_in, id_rs1_in, id_rs2_in,
           id_rs1_rd_in, id_rs2_rd_in, br_taken_in, br_target_in,
    output stall_out, flush_out, redirect_valid_out, redirect_pc_out,
           if_discard_out, hang_out
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources read in ID.
module pipe_ctrl_hazard_detect (
  input  logic       ex_is_load,
  input  logic       ex_wr,
  input  logic [4:0] ex_rsd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_rd,
  input  logic       id_rs2_rd,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real destination, so it can never create a hazard.
  always_comb begin
    rs1_hit  = id_rs1_rd && (id_rs1 == ex_rsd);
    rs2_hit  = id_rs2_rd && (id_rs2 == ex_rsd);
    load_use = ex_is_load && ex_wr && (ex_rsd != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall vector, load-use bubble, branch
// flush/redirect, stale-fetch discard and memory-stall watchdog.
// Optional build macro PIPE_CTRL_PERF_EN adds saturating perf counters.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  ST_RUN     | normal operation, no stale fetch outstanding
//  ST_DISCARD | fetch issued before a redirect is still in flight; drop it
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WDOG_MAX = 1024
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int PERF_W   = 32
`endif
) (
  input  logic              clk_in,
  input  logic              rst_in,
  pipe_ctrl_if.slave        bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_cyc_out,
  output logic [PERF_W-1:0] perf_stall_out,
  output logic [PERF_W-1:0] perf_flush_out,
  output logic [PERF_W-1:0] perf_loaduse_out
`endif
);

  localparam int               WD_W    = $clog2(WDOG_MAX + 1);
  localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(WDOG_MAX);

  ctrl_state_t        state_q, state_d;
  logic               load_use;
  logic               lu_stall;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               discard;
  logic [WD_W-1:0]    wdog_rem_q;
  logic               hang_q;

  pipe_ctrl_hazard_detect u_hazard (
    .ex_is_load (bus.ex_is_load_in),
    .ex_wr      (bus.ex_wr_in),
    .ex_rsd     (bus.ex_rsd_in),
    .id_rs1     (bus.id_rs1_in),
    .id_rs2     (bus.id_rs2_in),
    .id_rs1_rd  (bus.id_rs1_rd_in),
    .id_rs2_rd  (bus.id_rs2_rd_in),
    .load_use   (load_use)
  );

  // Discard state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Priority stall/flush decode and discard next-state; everything is held while rdy_in is low.
  always_comb begin
    stall       = STALL_NONE;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    discard     = 1'b0;
    lu_stall    = 1'b0;
    state_d     = state_q;
    if (!rst_in) begin
      if (!bus.rdy_in) begin
        stall = STALL_ALL;
      end else if (bus.stallreq_mem_in) begin
        // A taken branch stays in EX and is seen again once MEM completes.
        stall = STALL_MEM;
      end else if (bus.br_taken_in) begin
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = bus.br_target_in;
      end else if (load_use) begin
        stall    = STALL_LU;
        lu_stall = 1'b1;
      end else if (bus.stallreq_if_in) begin
        stall = STALL_IF;
      end

      if (state_q == ST_DISCARD) begin
        discard = 1'b1;
        // ALL and MEM masks already cover the IF bubble bits.
        stall   = stall | STALL_IF;
      end

      if (bus.rdy_in) begin
        unique case (state_q)
          ST_RUN: begin
            if (flush && bus.if_busy_in && !bus.if_fetch_done_in) state_d = ST_DISCARD;
          end
          ST_DISCARD: begin
            // A new redirect means the next returning fetch is stale as well.
            if (!flush && bus.if_fetch_done_in) state_d = ST_RUN;
          end
          default: state_d = ST_RUN;
        endcase
      end
    end
  end

  // Watchdog: down-counter reloaded whenever MEM is not stalling; terminal count sets sticky hang.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wdog_rem_q <= WD_LOAD;
      hang_q     <= 1'b0;
    end else if (bus.rdy_in) begin
      if (bus.stallreq_mem_in) begin
        if (wdog_rem_q != '0)            wdog_rem_q <= wdog_rem_q - 1'b1;
        if (wdog_rem_q == WD_W'(1))      hang_q     <= 1'b1;
      end else begin
        wdog_rem_q <= WD_LOAD;
      end
    end
  end

  assign bus.stall_out          = stall;
  assign bus.flush_out          = flush;
  assign bus.redirect_valid_out = redirect;
  assign bus.redirect_pc_out    = redirect_pc;
  assign bus.if_discard_out     = discard;
  assign bus.hang_out           = hang_q;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  logic [PERF_W-1:0] cyc_q, stall_cnt_q, flush_cnt_q, lu_cnt_q;

  // Saturating event counters, frozen together with the core.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cyc_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else if (bus.rdy_in) begin
      if (cyc_q != PERF_MAX)                               cyc_q       <= cyc_q + 1'b1;
      if ((stall != STALL_NONE) && (stall_cnt_q != PERF_MAX)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != PERF_MAX))              flush_cnt_q <= flush_cnt_q + 1'b1;
      if (lu_stall && (lu_cnt_q != PERF_MAX))              lu_cnt_q    <= lu_cnt_q + 1'b1;
    end
  end

  assign perf_cyc_out     = cyc_q;
  assign perf_stall_out   = stall_cnt_q;
  assign perf_flush_out   = flush_cnt_q;
  assign perf_loaduse_out = lu_cnt_q;
`else
  logic unused_lu;
  assign unused_lu = lu_stall;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random stimulus
// against a cycle-level reference model of the controller rules.
module tb_pipe_ctrl;

  localparam int WDOG = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  bit m_disc = 1'b0;
  int m_wd   = 0;
  bit m_hang = 1'b0;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.WDOG_MAX(WDOG)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_in();
    bus.rdy_in = 1'b1;          bus.stallreq_if_in = 1'b0;  bus.stallreq_mem_in = 1'b0;
    bus.if_busy_in = 1'b0;      bus.if_fetch_done_in = 1'b0;
    bus.ex_is_load_in = 1'b0;   bus.ex_wr_in = 1'b0;        bus.ex_rsd_in = 5'd0;
    bus.id_rs1_in = 5'd0;       bus.id_rs2_in = 5'd0;
    bus.id_rs1_rd_in = 1'b0;    bus.id_rs2_rd_in = 1'b0;
    bus.br_taken_in = 1'b0;     bus.br_target_in = 32'd0;
  endtask

  // Check all outputs against the model for the current inputs, then advance one clock.
  task automatic step();
    bit        lu, e_flush, n_disc;
    bit [5:0]  e_stall;
    bit [31:0] e_pc;
    #1;
    lu = bus.ex_is_load_in && bus.ex_wr_in && bus.ex_rsd_in != 0 &&
         ((bus.id_rs1_rd_in && bus.id_rs1_in == bus.ex_rsd_in) ||
          (bus.id_rs2_rd_in && bus.id_rs2_in == bus.ex_rsd_in));
    e_stall = 6'd0; e_flush = 1'b0; e_pc = 32'd0;
    if (!rst) begin
      if (!bus.rdy_in)               e_stall = 6'b111111;
      else if (bus.stallreq_mem_in)  e_stall = 6'b011111;
      else if (bus.br_taken_in) begin e_flush = 1'b1; e_pc = bus.br_target_in; end
      else if (lu)                   e_stall = 6'b000111;
      else if (bus.stallreq_if_in)   e_stall = 6'b000011;
      if (m_disc) e_stall = e_stall | 6'b000011;
    end
    chk("stall",    32'(bus.stall_out), 32'(e_stall));
    chk("flush",    32'(bus.flush_out), 32'(e_flush));
    chk("redir_v",  32'(bus.redirect_valid_out), 32'(e_flush));
    chk("redir_pc", bus.redirect_pc_out, e_pc);
    chk("discard",  32'(bus.if_discard_out), 32'(m_disc && !rst));
    chk("hang",     32'(bus.hang_out), 32'(m_hang));
    n_disc = m_disc;
    if (rst) begin
      n_disc = 1'b0; m_wd = 0; m_hang = 1'b0;
    end else if (bus.rdy_in) begin
      if (bus.stallreq_mem_in) begin
        if (m_wd < WDOG) m_wd++;
        if (m_wd == WDOG) m_hang = 1'b1;
      end else begin
        m_wd = 0;
      end
      if (m_disc) n_disc = e_flush || !bus.if_fetch_done_in;
      else        n_disc = e_flush && bus.if_busy_in && !bus.if_fetch_done_in;
    end
    @(posedge clk);
    m_disc = n_disc;
    @(negedge clk);
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;
    step();

    // load-use on rs1 -> ID_EX bubble
    bus.ex_is_load_in = 1'b1; bus.ex_wr_in = 1'b1; bus.ex_rsd_in = 5'd5;
    bus.id_rs1_in = 5'd5; bus.id_rs1_rd_in = 1'b1;
    #1 chk("t1_lu_stall", 32'(bus.stall_out), 32'h07);
    step();
    // same with x0 destination -> no hazard
    bus.ex_rsd_in = 5'd0; bus.id_rs1_in = 5'd0;
    #1 chk("t2_x0_stall", 32'(bus.stall_out), 32'h00);
    step();
    idle_in();

    // taken branch with fetch in flight -> redirect then discard
    bus.br_taken_in = 1'b1; bus.br_target_in = 32'h100; bus.if_busy_in = 1'b1;
    #1 chk("t3_redir_pc", bus.redirect_pc_out, 32'h100);
    step();
    bus.br_taken_in = 1'b0;
    #1 chk("t3_discard", 32'(bus.if_discard_out), 32'd1);
    step();
    bus.if_fetch_done_in = 1'b1;
    step();
    bus.if_fetch_done_in = 1'b0; bus.if_busy_in = 1'b0;
    #1 chk("t3_back_run", 32'(bus.if_discard_out), 32'd0);
    step();

    // branch held behind mem stall, flushes once released
    bus.br_taken_in = 1'b1; bus.br_target_in = 32'h2000; bus.stallreq_mem_in = 1'b1;
    #1 chk("t4_mem_stall", 32'(bus.stall_out), 32'h1f);
    step();
    bus.stallreq_mem_in = 1'b0;
    #1 chk("t4_flush", 32'(bus.flush_out), 32'd1);
    step();
    idle_in();

    // rdy low during DISCARD freezes, reset mid-DISCARD clears
    bus.br_taken_in = 1'b1; bus.br_target_in = 32'h40; bus.if_busy_in = 1'b1;
    step();
    idle_in(); bus.rdy_in = 1'b0; bus.if_fetch_done_in = 1'b1;
    #1 chk("t6_frozen", 32'(bus.stall_out), 32'h3f);
    step();
    bus.rdy_in = 1'b1; bus.if_fetch_done_in = 1'b0;
    #1 chk("t6_held", 32'(bus.if_discard_out), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 chk("t6_rst_run", 32'(bus.if_discard_out), 32'd0);
    step();

    // watchdog: hang sets after WDOG consecutive mem-stall cycles and stays
    bus.stallreq_mem_in = 1'b1;
    for (int i = 0; i < WDOG - 1; i++) step();
    #1 chk("t5_no_hang", 32'(bus.hang_out), 32'd0);
    step();
    #1 chk("t5_hang", 32'(bus.hang_out), 32'd1);
    bus.stallreq_mem_in = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst                  = ($urandom_range(0, 99) < 2);
      bus.rdy_in           = ($urandom_range(0, 9) != 0);
      bus.stallreq_mem_in  = ($urandom_range(0, 99) < 15);
      bus.stallreq_if_in   = ($urandom_range(0, 99) < 20);
      bus.if_busy_in       = $urandom_range(0, 1) == 1;
      bus.if_fetch_done_in = ($urandom_range(0, 99) < 30);
      bus.ex_is_load_in    = $urandom_range(0, 1) == 1;
      bus.ex_wr_in         = ($urandom_range(0, 3) != 0);
      bus.ex_rsd_in        = 5'($urandom_range(0, 3));
      bus.id_rs1_in        = 5'($urandom_range(0, 3));
      bus.id_rs2_in        = 5'($urandom_range(0, 3));
      bus.id_rs1_rd_in     = $urandom_range(0, 1) == 1;
      bus.id_rs2_rd_in     = $urandom_range(0, 1) == 1;
      bus.br_taken_in      = ($urandom_range(0, 99) < 15);
      bus.br_target_in     = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
